writeback_arbiter: RTL
======================

// Module: writeback_arbiter
// PURPOSE
//  Multi-source write-back stage for the RV32IM multi-cycle/pipelined core. Replaces
//  the single-cycle write-back select with a registered arbiter. Producers (ALU/PC+4,
//  load unit, mul/div unit, ...) each offer a result via valid/ready; one is granted
//  per cycle. Load results are byte/half-formatted. Output drives the register-file
//  write port one cycle after grant.
// PARAMETERS
//  WIDTH      32  datapath width (load formatting extends to WIDTH)
//  NUM_SRC    4   number of producer channels, >=2
//  REG_AW     5   register address width
//  LOAD_CH    1   channel index whose data gets load formatting, 0..NUM_SRC-1
//  RR_MODE    1   1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               async active-low reset
//  src_valid    in   NUM_SRC         per-channel result valid
//  src_ready    out  NUM_SRC         per-channel grant/accept (one-hot or zero)
//  src_data     in   NUM_SRC*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  src_rd       in   NUM_SRC*REG_AW  destination register, channel i at [i*REG_AW +: REG_AW]
//  ld_funct3    in   3               load type for LOAD_CH, sampled with its data
//  ld_byte_off  in   2               address[1:0] of the load, sampled with its data
//  flush        in   1               sync kill: no grant this cycle
//  rf_we        out  1               register-file write enable
//  rf_waddr     out  REG_AW          register-file write address
//  rf_wdata     out  WIDTH           register-file write data
// BEHAVIOUR
//  - Reset (rst_n=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0; src_ready=0.
//  - Handshake: transfer on channel i when src_valid[i] & src_ready[i] at a rising
//    edge. src_ready is combinational from src_valid, rr_ptr and flush; never depends
//    on src_data. At most one bit set. Producers hold valid/data/rd stable until accepted.
//  - RR_MODE=1: grant first valid channel searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//    On a transfer from channel g, rr_ptr <= (g+1) mod NUM_SRC. No transfer: rr_ptr held.
//  - RR_MODE=0: grant lowest-index valid channel; rr_ptr unused (stays 0).
//  - flush=1: src_ready=0 all channels, rr_ptr held, next-cycle rf_we=0.
//  - Latency 1: data accepted at edge N appears on rf_* from edge N until edge N+1.
//    rf_we=1 only for the cycle after a transfer; otherwise 0 (rf_waddr/rf_wdata hold).
//  - x0 suppression: transfer with rd==0 is accepted (ready=1) but rf_we stays 0.
//  - Load formatting (channel LOAD_CH only; others pass data unchanged):
//    000 LB : sign-ext byte  data[8*off +: 8]
//    001 LH : sign-ext half  data[16*off[1] +: 16]  (off[0] ignored)
//    010 LW : data
//    100 LBU: zero-ext byte  data[8*off +: 8]
//    101 LHU: zero-ext half  data[16*off[1] +: 16]
//    other  : data unchanged (illegal funct3 never traps here)
//  - Back-to-back: one transfer every cycle is sustained; no bubble between grants.
//  - Reset mid-operation: any pending rf_we is dropped; an accepted-but-unwritten
//    result is lost (upstream is also reset).
// TESTING
//  1 Reset: rst_n=0 with all valid=1 -> src_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0.
//  2 Single ALU write: ch0 valid, rd=5, data=0x0000_1234 -> ready[0]=1; next cycle
//    rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; following cycle rf_we=0.
//  3 Load format: ch1 data=0x80FF_7F01; LB off=2 -> 0xFFFF_FFFF; LBU off=3 -> 0x0000_0080;
//    LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01; LW -> 0x80FF_7F01.
//  4 Round-robin: all 4 valid held 8 cycles -> grants 0,1,2,3,0,1,2,3; RR_MODE=0 -> 0 x8.
//  5 x0 + flush: ch2 rd=0 -> ready[2]=1, rf_we=0 next cycle; flush=1 with ch0 valid ->
//    ready=0, rr_ptr unchanged, ch0 granted the cycle after flush drops.
//  6 Async reset mid-stream: rst_n low between edges during back-to-back writes ->
//    rf_we falls immediately; after release, arbitration restarts from ch0.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Bundle between the write-back producers and the arbiter, plus the
// register-file write port the arbiter drives.
interface writeback_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 5
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*WIDTH-1:0]  src_data;
  logic [NUM_SRC*REG_AW-1:0] src_rd;
  logic [2:0]                ld_funct3;
  logic [1:0]                ld_byte_off;
  logic                      flush;
  logic                      rf_we;
  logic [REG_AW-1:0]         rf_waddr;
  logic [WIDTH-1:0]          rf_wdata;

  modport master (
    output src_valid, src_data, src_rd, ld_funct3, ld_byte_off, flush,
    input  src_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  src_valid, src_data, src_rd, ld_funct3, ld_byte_off, flush,
    output src_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Registered multi-source write-back arbiter: grants one producer per cycle,
// formats load results and drives the register-file write port a cycle later.
module writeback_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 5,
  parameter int LOAD_CH = 1,
  parameter int RR_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic               rfWe_q, rfWe_d;
  logic [REG_AW-1:0]  rfWaddr_q, rfWaddr_d;
  logic [WIDTH-1:0]   rfWdata_q, rfWdata_d;

  logic               grantValid;
  logic [PTR_W-1:0]   grantIdx;
  logic [PTR_W-1:0]   candIdx;
  int                 candSum;
  logic [NUM_SRC-1:0] readyVec;
  logic [WIDTH-1:0]   selData;
  logic [WIDTH-1:0]   wrData;
  logic [REG_AW-1:0]  selRd;

  function automatic logic [WIDTH-1:0] fmtLoad(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       f3,
                                               input logic [1:0]       off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmtLoad = {{(WIDTH-8){b[7]}}, b};
      3'b001:  fmtLoad = {{(WIDTH-16){h[15]}}, h};
      3'b100:  fmtLoad = {{(WIDTH-8){1'b0}}, b};
      3'b101:  fmtLoad = {{(WIDTH-16){1'b0}}, h};
      default: fmtLoad = d;
    endcase
  endfunction

  // Walk candidates from highest search offset down so the nearest valid one
  // (offset 0 from rr pointer, or lowest index in fixed mode) is kept last.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    candSum    = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      candSum = (RR_MODE != 0) ? int'(rrPtr_q) + k : k;
      candIdx = PTR_W'(candSum % NUM_SRC);
      if (bus.src_valid[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
    if (bus.flush || !rst_n) begin
      grantValid = 1'b0;
    end
    readyVec = grantValid ? (NUM_SRC'(1) << grantIdx) : '0;
  end

  always_comb begin
    selData = '0;
    selRd   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grantIdx == PTR_W'(i)) begin
        selData = bus.src_data[i*WIDTH +: WIDTH];
        selRd   = bus.src_rd[i*REG_AW +: REG_AW];
      end
    end
    wrData = (grantIdx == PTR_W'(LOAD_CH))
           ? fmtLoad(selData, bus.ld_funct3, bus.ld_byte_off) : selData;
  end

  // Writes to x0 are still accepted upstream but never reach the register file.
  always_comb begin
    rfWe_d    = grantValid && (selRd != '0);
    rfWaddr_d = rfWe_d ? selRd  : rfWaddr_q;
    rfWdata_d = rfWe_d ? wrData : rfWdata_q;
    rrPtr_d   = rrPtr_q;
    if ((RR_MODE != 0) && grantValid) begin
      rrPtr_d = (grantIdx == PTR_W'(NUM_SRC - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q   <= '0;
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      rfWe_q    <= rfWe_d;
      rfWaddr_q <= rfWaddr_d;
      rfWdata_q <= rfWdata_d;
    end
  end

  assign bus.src_ready = readyVec;
  assign bus.rf_we     = rfWe_q;
  assign bus.rf_waddr  = rfWaddr_q;
  assign bus.rf_wdata  = rfWdata_q;
endmodule
